// File: rtl/sram_controller.sv
// Bridges a single-cycle 32-bit data-memory request onto a 16-bit asynchronous SRAM,
// splitting each access into a low and a high half-word transaction and freezing the pipeline meanwhile.
module sram_controller #(
    parameter int WAIT_CYCLES = 2,
    parameter int DATA_BASE   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_o,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_i,
    output logic        sram_we_n
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          is_wr;
    logic          last;
    logic [16:0]   hw_idx;

    // Word index inside the SRAM window; byte offset bits are dropped by the shift.
    assign hw_idx = 17'((address - 32'(DATA_BASE)) >> 2);
    assign last   = (cnt == CW'(WAIT_CYCLES - 1));
    assign ready  = (state == DONE) | ((state == IDLE) & ~mem_r_en & ~mem_w_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            is_wr      <= 1'b0;
            read_data  <= '0;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_r_en | mem_w_en) begin
                        state      <= LOW;
                        cnt        <= '0;
                        // Write wins when both enables are raised together.
                        is_wr      <= mem_w_en;
                        sram_addr  <= {hw_idx, 1'b0};
                        sram_we_n  <= ~mem_w_en;
                        sram_dq_oe <= mem_w_en;
                        sram_dq_o  <= mem_w_en ? write_data[15:0] : 16'h0000;
                    end
                end
                LOW: begin
                    if (last) begin
                        cnt       <= '0;
                        state     <= HIGH;
                        sram_addr <= {hw_idx, 1'b1};
                        sram_dq_o <= is_wr ? write_data[31:16] : 16'h0000;
                        if (!is_wr) read_data[15:0] <= sram_dq_i;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HIGH: begin
                    if (last) begin
                        cnt        <= '0;
                        state      <= DONE;
                        sram_addr  <= '0;
                        sram_dq_o  <= '0;
                        sram_we_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        if (!is_wr) read_data[31:16] <= sram_dq_i;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural 16-bit SRAM and a scoreboard monitor.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en, mem_w_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_i;
    logic        sram_we_n;

    logic [15:0] mem [0:262143];

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    int lat = 0;

    always #5 clk = ~clk;

    sram_controller #(.WAIT_CYCLES(2), .DATA_BASE(1024)) dut (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i), .sram_we_n(sram_we_n)
    );

    // Asynchronous SRAM: combinational read, write while the strobe is low.
    assign sram_dq_i = mem[sram_addr];
    always @(posedge clk) if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_o;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a completed access is ready=1 while the request is still held.
    always @(negedge clk) begin
        if (rst) begin
            lat = 0;
        end else if (mem_r_en || mem_w_en) begin
            if (!ready) begin
                lat++;
            end else begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_done: got read_data %h with empty scoreboard", read_data);
                end else begin
                    chk("read_data", read_data, exp_q.pop_front());
                    chk("latency", 32'(lat), 32'd5);
                end
                lat = 0;
            end
        end
    end

    // Called just after a rising edge with the controller idle; returns just after the edge leaving DONE.
    task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, output int we_low, output int oe_hi,
                          output logic [17:0] a_first, output logic [17:0] a_last);
        int  cyc;
        bit  first;
        exp_q.push_back(exp_rd);
        mem_r_en = r; mem_w_en = w; address = a; write_data = d;
        we_low = 0; oe_hi = 0; first = 1; cyc = 0; a_first = '0; a_last = '0;
        forever begin
            @(negedge clk);
            if (!sram_we_n) begin
                we_low++;
                if (first) a_first = sram_addr;
                first = 0;
                a_last = sram_addr;
            end
            if (sram_dq_oe) oe_hi++;
            if (ready) break;
            cyc++;
            if (cyc > 40) begin
                n_cmp++; n_bad++;
                $display("FAIL timeout: ready still %b after %0d cycles, required 1", ready, cyc);
                break;
            end
        end
        @(posedge clk); #1;
        mem_r_en = 1'b0; mem_w_en = 1'b0;
    endtask

    initial begin
        int we_low, oe_hi;
        logic [17:0] af, al;

        rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; address = '0; write_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_we_n", 32'(sram_we_n), 32'd1);
        chk("reset_oe", 32'(sram_dq_oe), 32'd0);
        chk("reset_rdata", read_data, 32'h0);
        chk("reset_addr", 32'(sram_addr), 32'd0);
        @(posedge clk); #1;

        access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0, we_low, oe_hi, af, al);
        chk("wr_we_low_cycles", 32'(we_low), 32'd4);
        chk("wr_mem0", 32'(mem[0]), 32'h0000BEEF);
        chk("wr_mem1", 32'(mem[1]), 32'h0000DEAD);

        access(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, we_low, oe_hi, af, al);
        chk("rd_oe_cycles", 32'(oe_hi), 32'd0);
        chk("rd_we_low_cycles", 32'(we_low), 32'd0);

        access(1'b0, 1'b1, 32'd1032, 32'h12345678, 32'hDEADBEEF, we_low, oe_hi, af, al);
        chk("map_first_addr", 32'(af), 32'd4);
        chk("map_last_addr", 32'(al), 32'd5);

        access(1'b1, 1'b0, 32'd1032, 32'h0, 32'h12345678, we_low, oe_hi, af, al);
        access(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, we_low, oe_hi, af, al);

        access(1'b1, 1'b1, 32'd1036, 32'hCAFEF00D, 32'hDEADBEEF, we_low, oe_hi, af, al);
        chk("both_mem6", 32'(mem[6]), 32'h0000F00D);
        chk("both_mem7", 32'(mem[7]), 32'h0000CAFE);
        chk("both_we_low_cycles", 32'(we_low), 32'd4);

        // Abort a write during its high half-word phase.
        mem_w_en = 1'b1; address = 32'd1040; write_data = 32'h11112222;
        repeat (4) @(negedge clk);
        chk("abort_in_high_we_n", 32'(sram_we_n), 32'd0);
        chk("abort_in_high_addr", 32'(sram_addr), 32'd9);
        rst = 1'b1; mem_w_en = 1'b0;
        @(negedge clk);
        chk("abort_we_n", 32'(sram_we_n), 32'd1);
        chk("abort_oe", 32'(sram_dq_oe), 32'd0);
        chk("abort_addr", 32'(sram_addr), 32'd0);
        chk("abort_dq_o", 32'(sram_dq_o), 32'd0);
        chk("abort_rdata", read_data, 32'h0);
        chk("abort_ready", 32'(ready), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        access(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, we_low, oe_hi, af, al);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle bridge between the MEM stage's single-cycle data-memory request (mem_r_en / mem_w_en / address / write_data) and an external 16-bit asynchronous SRAM. Each 32-bit access is split into two 16-bit SRAM transactions. `ready` is deasserted until the access completes, so the pipeline uses `~ready` as a global freeze. The block replaces the single-cycle RAM when the CPU runs against board-level SRAM. It is instantiated beside the CPU in the top-level testbench together with a behavioural SRAM model.

## Interface
Parameters:
- WAIT_CYCLES, 2: cycles each half-word transaction holds address, data and strobes stable (≥1).
- DATA_BASE, 1024: byte address that maps to SRAM half-word 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- mem_r_en  input  1  read request from the MEM stage.
- mem_w_en  input  1  write request from the MEM stage.
- address  input  32  byte address from the ALU result.
- write_data  input  32  store data.
- read_data  output  32  load data, registered.
- ready  output  1  access complete or idle; the pipeline freezes when this is 0.
- sram_addr  output  18  SRAM half-word address.
- sram_dq_o  output  16  SRAM write data.
- sram_dq_oe  output  1  drive enable for the sram_dq_o bus.
- sram_dq_i  input  16  SRAM read data.
- sram_we_n  output  1  SRAM write strobe, active-low.

## Operation
- Address mapping: local = address − DATA_BASE, computed modulo 2^32. Low half-word address = {local[18:2], 1'b0}; high half-word address = {local[18:2], 1'b1}. There is no range check. local[1:0] is ignored.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: if (mem_r_en | mem_w_en), go to LOW and load the wait counter with 0. Otherwise stay in IDLE.
  - LOW / HIGH: the counter increments each cycle. On the cycle where counter = WAIT_CYCLES−1, the counter resets and the FSM advances LOW→HIGH or HIGH→DONE.
  - DONE: lasts exactly one cycle, then returns to IDLE unconditionally.
- When both mem_r_en and mem_w_en are high, the write takes priority and the access is treated as a write.
- Write:
  - LOW drives write_data[15:0]; HIGH drives write_data[31:16].
  - sram_dq_oe = 1 and sram_we_n = 0 for every cycle of LOW and HIGH.
- Read:
  - sram_dq_oe = 0 and sram_we_n = 1.
  - sram_dq_i is captured into read_data[15:0] on the last LOW cycle and into read_data[31:16] on the last HIGH cycle.
- In IDLE and DONE: sram_we_n = 1, sram_dq_oe = 0, sram_addr = 0, sram_dq_o = 0.
- ready (combinational) = (state == DONE) | (state == IDLE & ~mem_r_en & ~mem_w_en).
- read_data holds its value until the next read overwrites it. Writes never change read_data.
- The MEM stage holds its request inputs stable while ready = 0. Inputs are sampled every cycle and are not latched.

## Timing
- Reset values: FSM = IDLE, counter = 0, read_data = 0, sram_we_n = 1, sram_dq_oe = 0, sram_addr = 0, sram_dq_o = 0. ready = 1 if no request is present.
- If a request first appears in cycle n (state IDLE):
  - ready = 0 in cycles n … n+2·WAIT_CYCLES.
  - ready = 1 in cycle n+2·WAIT_CYCLES+1 (DONE). For a read, read_data is valid in that cycle.
  - Total latency = 2·WAIT_CYCLES+2 cycles.
- Back-to-back accesses: after DONE the FSM returns to IDLE. If the next instruction's request is already present in that cycle, ready = 0 immediately and the next access starts at the following edge. Accesses never overlap.
- If the request drops during LOW or HIGH (protocol violation), the FSM still completes the sequence.
- rst asserted mid-access: at the next edge the FSM returns to IDLE and all outputs take their reset values. No partial-write completion is guaranteed.

## Test plan
- Reset idle: rst=1 for 2 cycles, then no request → ready=1, sram_we_n=1, sram_dq_oe=0, read_data=0.
- Write, WAIT_CYCLES=2: mem_w_en=1, address=1024, write_data=0xDEADBEEF → ready=0 for 5 cycles then 1. SRAM model holds [0]=0xBEEF and [1]=0xDEAD. sram_we_n is low for exactly 4 cycles.
- Read back: mem_r_en=1, address=1024 → read_data=0xDEADBEEF in the DONE cycle (6th cycle). sram_dq_oe=0 throughout.
- Address mapping: a write of 0x12345678 to address 1032 drives sram_addr 4 then 5. A read of 1032 returns 0x12345678. A read of 1024 still returns 0xDEADBEEF.
- Both enables high, with write_data=0xCAFEF00D and address=1036 → write behaviour is performed. SRAM [6]=0xF00D, [7]=0xCAFE. read_data is unchanged.
- Reset mid-write: rst=1 during the HIGH phase → the next cycle shows IDLE outputs. A new read afterwards completes normally with the 6-cycle latency.
